// File: rtl/ifft16_iter.sv
// Iterative 16-point inverse FFT: one radix-2 DIF butterfly per cycle over an in-place
// register file, bit-reversed unload into a held output register.
module ifft16_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] x,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] y,
  output logic         out_valid
);

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e      state;
  logic [1:0]  stage;
  logic [2:0]  bfly;
  logic [31:0] mem [16];

  logic [3:0]  span, mask, jj, top, bot;
  logic [2:0]  tw_idx;
  logic signed [15:0] ar, ai, br, bi, c_tw, s_tw;
  logic signed [16:0] sum_r, sum_i, d_r, d_i;
  logic signed [33:0] m_r, m_i;
  logic [31:0] top_new, bot_new;

  function automatic logic signed [15:0] tw_cos(input logic [2:0] k);
    case (k)
      3'd0:    return 16'sd16384;
      3'd1:    return 16'sd15137;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd6270;
      3'd4:    return 16'sd0;
      3'd5:    return -16'sd6270;
      3'd6:    return -16'sd11585;
      default: return -16'sd15137;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_sin(input logic [2:0] k);
    case (k)
      3'd0:    return 16'sd0;
      3'd1:    return 16'sd6270;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd15137;
      3'd4:    return 16'sd16384;
      3'd5:    return 16'sd15137;
      3'd6:    return 16'sd11585;
      default: return 16'sd6270;
    endcase
  endfunction

  function automatic logic [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767)       return 16'h7fff;
    else if (v < -34'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  assign in_ready = (state == StIdle);

  // Addressing: span is a power of two, so div/mod reduce to masking.
  always_comb begin
    span   = 4'd8 >> stage;
    mask   = span - 4'd1;
    jj     = {1'b0, bfly};
    top    = ((jj & ~mask) << 1) | (jj & mask);
    bot    = top + span;
    tw_idx = 3'((jj & mask) << stage);
  end

  always_comb begin
    ar    = $signed(mem[top][31:16]);
    ai    = $signed(mem[top][15:0]);
    br    = $signed(mem[bot][31:16]);
    bi    = $signed(mem[bot][15:0]);
    c_tw  = tw_cos(tw_idx);
    s_tw  = tw_sin(tw_idx);
    sum_r = 17'(ar) + 17'(br);
    sum_i = 17'(ai) + 17'(bi);
    d_r   = 17'(ar) - 17'(br);
    d_i   = 17'(ai) - 17'(bi);
    // Q2.14 twiddle with a >>>15 shift also folds in the per-stage 1/2 scaling.
    m_r   = 34'(d_r) * 34'(c_tw) - 34'(d_i) * 34'(s_tw);
    m_i   = 34'(d_r) * 34'(s_tw) + 34'(d_i) * 34'(c_tw);
    top_new = {sat16(34'(sum_r >>> 1)), sat16(34'(sum_i >>> 1))};
    bot_new = {sat16(m_r >>> 15), sat16(m_i >>> 15)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      stage     <= 2'd0;
      bfly      <= 3'd0;
      y         <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) mem[i] <= x[32*i +: 32];
            stage <= 2'd0;
            bfly  <= 3'd0;
            state <= StCalc;
          end
        end
        StCalc: begin
          mem[top] <= top_new;
          mem[bot] <= bot_new;
          if (bfly == 3'd7) begin
            bfly <= 3'd0;
            if (stage == 2'd3) state <= StOut;
            else               stage <= stage + 2'd1;
          end else begin
            bfly <= bfly + 3'd1;
          end
        end
        StOut: begin
          for (int i = 0; i < 16; i++) y[32*bitrev4(4'(i)) +: 32] <= mem[i];
          out_valid <= 1'b1;
          stage     <= 2'd0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft16_iter.sv
// Directed bench for ifft16_iter: impulse, constant, tone, handshake, reset, round trip.
module tb_ifft16_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] x = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] y;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  // 16384*cos/sin(2*pi*m/16), m = 0..7
  int c8 [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int s8 [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  ifft16_iter dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int re, input int im);
    logic [15:0] r, i;
    r = 16'(re);
    i = 16'(im);
    return {r, i};
  endfunction

  function automatic int yre(input logic [511:0] v, input int n);
    return int'($signed(v[32*n+16 +: 16]));
  endfunction

  function automatic int yim(input logic [511:0] v, input int n);
    return int'($signed(v[32*n +: 16]));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int cos16(input int m);
    return (m < 8) ? c8[m] : -c8[m-8];
  endfunction

  function automatic int sin16(input int m);
    return (m < 8) ? s8[m] : -s8[m-8];
  endfunction

  // Captures v on the next edge and returns edges until out_valid is seen (-1 on timeout).
  task automatic run_xform(input logic [511:0] v, output int lat);
    @(negedge clk);
    x = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got=%h want=0", y); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_impulse();
    logic [511:0] v;
    int lat;
    v = '0;
    v[31:0] = w(16384, 0);
    run_xform(v, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL impulse_latency got=%0d want=33", lat); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (y[32*n +: 32] !== w(1024, 0)) begin
        errors++; $display("FAIL impulse_y[%0d] got=%h want=%h", n, y[32*n +: 32], w(1024, 0));
      end
    end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL impulse_pulse_width got=%b want=0", out_valid); end
  endtask

  task automatic test_constant();
    logic [511:0] v;
    int lat;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = w(16384, 0);
    run_xform(v, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL constant_latency got=%0d want=33", lat); end
    for (int n = 0; n < 16; n++) begin
      int er;
      er = (n == 0) ? 16384 : 0;
      checks++;
      if (iabs(yre(y, n) - er) > 2 || iabs(yim(y, n)) > 2) begin
        errors++; $display("FAIL constant_y[%0d] got=(%0d,%0d) want=(%0d,0)+-2", n, yre(y, n), yim(y, n), er);
      end
    end
  endtask

  task automatic test_tone();
    logic [511:0] v;
    int lat;
    v = '0;
    v[63:32] = w(16384, 0);
    run_xform(v, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL tone_latency got=%0d want=33", lat); end
    for (int n = 0; n < 16; n++) begin
      int er, ei;
      er = (cos16(n) + 8) / 16;
      ei = (sin16(n) + 8) / 16;
      checks++;
      if (iabs(yre(y, n) - er) > 2 || iabs(yim(y, n) - ei) > 2) begin
        errors++; $display("FAIL tone_y[%0d] got=(%0d,%0d) want=(%0d,%0d)+-2", n, yre(y, n), yim(y, n), er, ei);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] imp, cst;
    int ov_count, ov1, ov2, busy_low;
    logic [511:0] y_first;
    imp = '0;
    imp[31:0] = w(16384, 0);
    for (int i = 0; i < 16; i++) cst[32*i +: 32] = w(16384, 0);
    ov_count = 0; ov1 = -1; ov2 = -1; busy_low = 0; y_first = '0;
    @(negedge clk);
    x = imp;
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (c <= 32 && in_ready == 1'b0) busy_low++;
      if (out_valid) begin
        ov_count++;
        if (ov1 < 0) begin ov1 = c; y_first = y; end
        else if (ov2 < 0) ov2 = c;
      end
      if (c == 5) x = cst;
      if (c == 66) in_valid = 1'b0;
    end
    checks++; if (ov1 !== 33) begin errors++; $display("FAIL b2b_first_out got=%0d want=33", ov1); end
    checks++; if (ov2 !== 67) begin errors++; $display("FAIL b2b_second_out got=%0d want=67", ov2); end
    checks++; if (ov_count !== 2) begin errors++; $display("FAIL b2b_out_count got=%0d want=2", ov_count); end
    checks++; if (busy_low !== 33) begin errors++; $display("FAIL b2b_in_ready_low got=%0d want=33", busy_low); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (y_first[32*n +: 32] !== w(1024, 0)) begin
        errors++; $display("FAIL b2b_first_y[%0d] got=%h want=%h", n, y_first[32*n +: 32], w(1024, 0));
      end
    end
    checks++;
    if (iabs(yre(y, 0) - 16384) > 2 || iabs(yre(y, 5)) > 2 || iabs(yim(y, 9)) > 2) begin
      errors++; $display("FAIL b2b_held_y got=(%0d,%0d,%0d) want=(16384,0,0)+-2", yre(y, 0), yre(y, 5), yim(y, 9));
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] v;
    int lat, ov_seen;
    v = '0;
    v[63:32] = w(16384, 0);
    @(negedge clk);
    x = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (y !== '0) begin errors++; $display("FAIL midrst_y got=%h want=0", y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen++;
    end
    checks++; if (ov_seen !== 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d want=0", ov_seen); end
    v = '0;
    v[31:0] = w(16384, 0);
    run_xform(v, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_latency got=%0d want=33", lat); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (y[32*n +: 32] !== w(1024, 0)) begin
        errors++; $display("FAIL midrst_y[%0d] got=%h want=%h", n, y[32*n +: 32], w(1024, 0));
      end
    end
  endtask

  task automatic test_round_trip();
    int xr [16], xi [16];
    logic [511:0] v;
    int lat;
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'($urandom_range(2000)) - 1000;
      xi[n] = int'($urandom_range(2000)) - 1000;
    end
    // Unscaled forward DFT (gain 16), so the inverse should give back x.
    for (int k = 0; k < 16; k++) begin
      longint sr, si;
      sr = 0;
      si = 0;
      for (int n = 0; n < 16; n++) begin
        int m;
        m = (n * k) % 16;
        sr += longint'(xr[n]) * cos16(m) + longint'(xi[n]) * sin16(m);
        si += longint'(xi[n]) * cos16(m) - longint'(xr[n]) * sin16(m);
      end
      v[32*k +: 32] = w(int'((sr + 8192) >>> 14), int'((si + 8192) >>> 14));
    end
    run_xform(v, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rt_latency got=%0d want=33", lat); end
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (iabs(yre(y, n) - xr[n]) > 3 || iabs(yim(y, n) - xi[n]) > 3) begin
        errors++; $display("FAIL rt_y[%0d] got=(%0d,%0d) want=(%0d,%0d)+-3", n, yre(y, n), yim(y, n), xr[n], xi[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_constant();
    test_tone();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
